// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Optional performance counters in the top are enabled by defining IF_PERF_CNT_EN.
package if_pkg;

    localparam int unsigned PC_STEP = 4;
    localparam int unsigned DEFAULT_WORD_BITWIDTH = 32;

    // Default-width entry; the top derives a width-matched twin from WORD_BITWIDTH.
    typedef struct packed {
        logic [DEFAULT_WORD_BITWIDTH-1:0] pc;
        logic [DEFAULT_WORD_BITWIDTH-1:0] inst;
    } fetch_entry_t;

    // Occupancy counters must represent 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/if_fetch_fifo.sv
// Synchronous first-word-fall-through FIFO of fetch entries.
// Clear has priority over push; a pop on an empty FIFO is ignored.
module if_fetch_fifo
    import if_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter int  CNT_W   = cnt_w(DEPTH),
    parameter type entry_t = fetch_entry_t
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  entry_t           push_data,
    input  logic             pop,
    output entry_t           head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    entry_t           mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO may still accept a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign count   = count_reg;
    assign head    = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !clear) begin
            assert (!(push && full && !pop));
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC generation, credit-limited imem requests, prefetch FIFO to ID.
// Define IF_PERF_CNT_EN to add saturating fetch/redirect/drop performance counters.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter int                       WORD_BITWIDTH = 32,
    parameter logic [WORD_BITWIDTH-1:0] RESET_PC      = '0,
    parameter int                       FIFO_DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     redirect_valid,
    input  logic [WORD_BITWIDTH-1:0] redirect_pc,
    output logic                     imem_req_valid,
    input  logic                     imem_req_ready,
    output logic [WORD_BITWIDTH-1:0] imem_req_addr,
    input  logic                     imem_rsp_valid,
    input  logic [WORD_BITWIDTH-1:0] imem_rsp_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WORD_BITWIDTH-1:0] out_pc,
    output logic [WORD_BITWIDTH-1:0] out_inst
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]              perf_fetch_cnt,
    output logic [31:0]              perf_redirect_cnt,
    output logic [31:0]              perf_drop_cnt
`endif
);

    localparam int W     = WORD_BITWIDTH;
    localparam int CNT_W = cnt_w(FIFO_DEPTH);
    localparam logic [W-1:0] STEP = W'(PC_STEP);

    typedef struct packed {
        logic [W-1:0] pc;
        logic [W-1:0] inst;
    } entry_t;

    logic [W-1:0]     fetch_pc_reg, fetch_pc_next;
    logic [W-1:0]     rsp_pc_reg, rsp_pc_next;
    logic [W-1:0]     target_pc;
    logic [CNT_W-1:0] outstanding_reg, outstanding_next;
    logic [CNT_W-1:0] drop_cnt_reg, drop_cnt_next;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   credit_used;
    logic             req_valid, req_accept;
    logic             rsp_drop, rsp_push, pop;
    logic             fifo_full, fifo_empty;
    entry_t           push_entry, head_entry;
    logic             unused_redirect_bits;

    assign target_pc            = {redirect_pc[W-1:2], 2'b00};
    assign unused_redirect_bits = ^redirect_pc[1:0];

    // Every slot is reserved at request time, so the FIFO can never overflow.
    assign credit_used = {1'b0, outstanding_reg} + {1'b0, fifo_count};
    assign req_valid   = !rst && !redirect_valid && (credit_used < (CNT_W+1)'(FIFO_DEPTH));
    assign req_accept  = req_valid && imem_req_ready;

    // Responses still owed to the old path, and any arriving with a redirect, are wrong-path.
    assign rsp_drop = imem_rsp_valid && (redirect_valid || (drop_cnt_reg != '0));
    assign rsp_push = imem_rsp_valid && !rsp_drop;
    assign pop      = out_valid && out_ready;

    assign push_entry.pc   = rsp_pc_reg;
    assign push_entry.inst = imem_rsp_data;

    assign imem_req_valid = req_valid;
    assign imem_req_addr  = fetch_pc_reg;
    assign out_valid      = !fifo_empty;
    assign out_pc         = fifo_empty ? '0 : head_entry.pc;
    assign out_inst       = fifo_empty ? '0 : head_entry.inst;

    always_comb begin
        fetch_pc_next    = fetch_pc_reg;
        rsp_pc_next      = rsp_pc_reg;
        drop_cnt_next    = drop_cnt_reg;
        outstanding_next = outstanding_reg + CNT_W'(req_accept) - CNT_W'(imem_rsp_valid);
        if (redirect_valid) begin
            fetch_pc_next = target_pc;
            rsp_pc_next   = target_pc;
            drop_cnt_next = outstanding_next;
        end else begin
            if (req_accept) begin
                fetch_pc_next = fetch_pc_reg + STEP;
            end
            if (rsp_push) begin
                rsp_pc_next = rsp_pc_reg + STEP;
            end
            if (rsp_drop) begin
                drop_cnt_next = drop_cnt_reg - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_reg    <= RESET_PC;
            rsp_pc_reg      <= RESET_PC;
            outstanding_reg <= '0;
            drop_cnt_reg    <= '0;
        end else begin
            fetch_pc_reg    <= fetch_pc_next;
            rsp_pc_reg      <= rsp_pc_next;
            outstanding_reg <= outstanding_next;
            drop_cnt_reg    <= drop_cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (outstanding_reg <= CNT_W'(FIFO_DEPTH));
            assert (!(rsp_push && fifo_full && !pop));
        end
    end

    if_fetch_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .CNT_W   (CNT_W),
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (redirect_valid),
        .push      (rsp_push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head_entry),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

`ifdef IF_PERF_CNT_EN
    logic [2:0] perf_inc;
    assign perf_inc = {rsp_drop, redirect_valid, req_accept};

    genvar gi;
    for (gi = 0; gi < 3; gi++) begin : g_perf
        logic [31:0] cnt_reg;
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_reg <= '0;
            end else if (perf_inc[gi] && !(&cnt_reg)) begin
                cnt_reg <= cnt_reg + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt    = g_perf[0].cnt_reg;
    assign perf_redirect_cnt = g_perf[1].cnt_reg;
    assign perf_drop_cnt     = g_perf[2].cnt_reg;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: in-order imem model plus a queue-based fetch-stream reference.
// Perf-counter checks are compiled in only when IF_PERF_CNT_EN is defined.
module tb_if_fetch_unit;

    localparam int          W   = 32;
    localparam int          D   = 4;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic          redirect_valid;
    logic [W-1:0]  redirect_pc;
    logic          imem_req_valid;
    logic          imem_req_ready;
    logic [W-1:0]  imem_req_addr;
    logic          imem_rsp_valid;
    logic [W-1:0]  imem_rsp_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_pc;
    logic [W-1:0]  out_inst;
`ifdef IF_PERF_CNT_EN
    logic [31:0]   perf_fetch_cnt;
    logic [31:0]   perf_redirect_cnt;
    logic [31:0]   perf_drop_cnt;
`endif

    always #5 clk = ~clk;

    if_fetch_unit #(
        .WORD_BITWIDTH (W),
        .RESET_PC      (RPC),
        .FIFO_DEPTH    (D)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch_cnt    (perf_fetch_cnt),
        .perf_redirect_cnt (perf_redirect_cnt),
        .perf_drop_cnt     (perf_drop_cnt)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        bit          stale;
        int          due;
    } req_t;

    req_t        infl[$];      // requests accepted by memory, oldest first
    logic [63:0] fifo_q[$];    // expected prefetch contents {pc, inst}
    logic [31:0] popped[$];    // PCs handed to ID
    logic [31:0] exp_fetch;
    int          cyc, last_due, lat_lo, lat_hi;
    int          n_checks, n_fail;
    int          m_acc, m_redir, m_drop;
    bit          obs_req_valid, obs_out_valid;
    logic [31:0] obs_req_addr;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive memory response, check outputs at negedge, advance reference.
    task automatic step();
        bit   exp_rv;
        bit   rsp_now;
        req_t r;
        int   lat;
        rsp_now = (infl.size() > 0) && (infl[0].due <= cyc);
        imem_rsp_valid = rsp_now;
        imem_rsp_data  = rsp_now ? inst_of(infl[0].addr) : $urandom;
        @(negedge clk);
        obs_req_valid = imem_req_valid;
        obs_req_addr  = imem_req_addr;
        obs_out_valid = out_valid;
        exp_rv = !redirect_valid && ((infl.size() + fifo_q.size()) < D);
        check("req_valid", {63'd0, imem_req_valid}, {63'd0, exp_rv});
        if (exp_rv) check("req_addr", {32'd0, imem_req_addr}, {32'd0, exp_fetch});
        check("out_valid", {63'd0, out_valid}, {63'd0, fifo_q.size() > 0});
        if (fifo_q.size() > 0) check("out_entry", {out_pc, out_inst}, fifo_q[0]);
        if (fifo_q.size() > 0 && out_ready) begin
            popped.push_back(fifo_q[0][63:32]);
            void'(fifo_q.pop_front());
        end
        if (rsp_now) begin
            r = infl.pop_front();
            if (r.stale || redirect_valid) m_drop++;
            else fifo_q.push_back({r.addr, inst_of(r.addr)});
        end
        if (imem_req_valid && imem_req_ready) begin
            lat = $urandom_range(lat_hi, lat_lo);
            last_due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
            infl.push_back('{imem_req_addr, 1'b0, last_due});
        end
        if (exp_rv && imem_req_ready) begin
            exp_fetch = exp_fetch + 32'd4;
            m_acc++;
        end
        if (redirect_valid) begin
            fifo_q.delete();
            foreach (infl[i]) infl[i].stale = 1'b1;
            exp_fetch = {redirect_pc[31:2], 2'b00};
            m_redir++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_pc", {32'd0, out_pc}, 64'd0);
        check("rst_out_inst", {32'd0, out_inst}, 64'd0);
`ifdef IF_PERF_CNT_EN
        check("rst_perf", {perf_fetch_cnt | perf_redirect_cnt | perf_drop_cnt}, 64'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        fifo_q.delete();
        infl.delete();
        popped.delete();
        exp_fetch = RPC;
        m_acc = 0; m_redir = 0; m_drop = 0;
        cyc = 0; last_due = 0;
    endtask

    task automatic run_until_pops(input int n, input int budget);
        int k;
        k = 0;
        while (popped.size() < n && k < budget) begin
            step();
            k++;
        end
        if (popped.size() < n) check("pop_timeout", popped.size(), n);
    endtask

    task automatic redirect_to(input logic [31:0] tgt);
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        step();
        redirect_valid = 1'b0;
        popped.delete();
    endtask

    initial begin
        int          first_valid;
        int          k;
        logic [31:0] exp_pc;
`ifdef IF_PERF_CNT_EN
        logic [31:0] drop_base;
`endif
        n_checks = 0; n_fail = 0;
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        out_ready = 1'b0;
        lat_lo = 1; lat_hi = 1;
        do_reset();

        // Steady flow: first output in the third cycle after reset release, then one per cycle.
        imem_req_ready = 1'b1; out_ready = 1'b1;
        first_valid = -1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (first_valid < 0 && obs_out_valid) first_valid = i;
        end
        check("first_valid_cycle", first_valid, 2);
        for (int i = 0; i < 4; i++) check("steady_pc", popped[i], 32'h4 * i);
        check("steady_rate", popped.size(), 10);

        // Stall ID: FIFO fills and requests stop, then an ordered drain.
        out_ready = 1'b0;
        repeat (10) step();
        check("stall_req_valid", obs_req_valid, 0);
        check("stall_out_valid", obs_out_valid, 1);
        popped.delete();
        out_ready = 1'b1;
        repeat (10) step();
        for (int i = 1; i < popped.size(); i++) check("drain_order", popped[i], popped[i-1] + 32'd4);

        // Redirect with exactly two requests in flight at latency 3.
        lat_lo = 3; lat_hi = 3;
        imem_req_ready = 1'b0;
        repeat (6) step();
        imem_req_ready = 1'b1;
        repeat (2) step();
        check("inflight_two", infl.size(), 2);
`ifdef IF_PERF_CNT_EN
        drop_base = perf_drop_cnt;
`endif
        redirect_to(32'h100);
        step();
        check("flush_empty", obs_out_valid, 0);
        run_until_pops(1, 40);
        check("redirect_first_pc", popped[0], 32'h100);
`ifdef IF_PERF_CNT_EN
        check("perf_drop_two", perf_drop_cnt - drop_base, 2);
`endif

        // Redirect in the same cycle as a response; unaligned target.
        lat_lo = 2; lat_hi = 2;
        repeat (6) step();
        k = 0;
        while (!(infl.size() > 0 && infl[0].due <= cyc) && k < 20) begin
            step();
            k++;
        end
        redirect_to(32'h203);
        step();
        check("align_req_valid", obs_req_valid, 1);
        check("align_req_addr", obs_req_addr, 32'h200);
        run_until_pops(1, 40);
        check("align_first_pc", popped[0], 32'h200);

        // Address wrap at the top of the space.
        lat_lo = 1; lat_hi = 1;
        redirect_to(32'hFFFF_FFF8);
        run_until_pops(4, 60);
        exp_pc = 32'hFFFF_FFF8;
        for (int i = 0; i < 4; i++) begin
            check("wrap_pc", popped[i], exp_pc);
            exp_pc = exp_pc + 32'd4;
        end

        // Randomised traffic with redirects, latency 1-4.
        lat_lo = 1; lat_hi = 4;
        for (int i = 0; i < 1500; i++) begin
            imem_req_ready = ($urandom_range(99) < 70);
            out_ready      = ($urandom_range(99) < 75);
            redirect_valid = ($urandom_range(99) < 4);
            redirect_pc    = $urandom;
            step();
        end
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1; out_ready = 1'b1;
        repeat (20) step();
`ifdef IF_PERF_CNT_EN
        check("perf_fetch", perf_fetch_cnt, m_acc);
        check("perf_redirect", perf_redirect_cnt, m_redir);
        check("perf_drop", perf_drop_cnt, m_drop);
`endif

        // Reset mid-run once memory is idle, then resume from RESET_PC.
        imem_req_ready = 1'b0;
        k = 0;
        while (infl.size() > 0 && k < 20) begin
            step();
            k++;
        end
        check("idle_before_reset", infl.size(), 0);
        do_reset();
        imem_req_ready = 1'b1; out_ready = 1'b1;
        run_until_pops(2, 20);
        check("post_reset_pc0", popped[0], RPC);
        check("post_reset_pc1", popped[1], RPC + 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
